backend_config_sequencer: RTL and testbench

- Sequences one backend_cycle_controller instance.
- Holds a host-writable shadow bank for the ten backend configuration words and streams them into the controller over its write_config_n/config_address/config_data port.
- Arms timer_enable, waits for update_cycle_complete, and repeats frames as configured.
- Sits between the host register interface and the backend cycle controller.

---
 rtl/backend_config_sequencer.sv | 150 +++++++++++++++
 tb/tb_backend_config_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/backend_config_sequencer.sv
// Backend configuration sequencer: host shadow bank, config streaming into the
// backend cycle controller, then timed RUN/GAP frames until the repeat count is met.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; host may write the shadow bank
// LOAD  | streaming one shadow word per cycle to the backend
// RUN   | timer_enable high, waiting for update_cycle_complete
// GAP   | timer_enable low so the backend timers clear between frames
module backend_config_sequencer #(
    parameter int NUM_CFG_REGS   = 10,
    parameter int MIN_RUN_CYCLES = 2,
    parameter int GAP_CYCLES     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        host_we,
    input  logic [3:0]  host_addr,
    input  logic [15:0] host_wdata,
    input  logic        start,
    input  logic        abort,
    input  logic        update_cycle_complete,
    output logic        write_config_n,
    output logic [5:0]  config_address,
    output logic [15:0] config_data,
    output logic        timer_enable,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frames_done,
    output logic        write_err
);

    localparam int IDX_W = $clog2(NUM_CFG_REGS + 1);
    localparam int RUN_W = (MIN_RUN_CYCLES < 1) ? 1 : $clog2(MIN_RUN_CYCLES + 1);
    localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);

    localparam logic [IDX_W-1:0] LOAD_END = IDX_W'(NUM_CFG_REGS);
    localparam logic [RUN_W-1:0] RUN_MIN  = RUN_W'(MIN_RUN_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
    localparam logic [3:0]       RPT_ADDR = 4'(NUM_CFG_REGS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_GAP
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] load_idx;
    logic [RUN_W-1:0] run_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [15:0]      shadow [NUM_CFG_REGS + 1];
    logic [15:0]      repeat_count;
    logic             run_exit;

    assign repeat_count = shadow[NUM_CFG_REGS];
    assign busy         = (state != ST_IDLE);
    // run_cnt saturates at the minimum, so >= reduces to equality
    assign run_exit     = update_cycle_complete && (run_cnt == RUN_MIN);

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= ST_IDLE;
            load_idx       <= '0;
            run_cnt        <= '0;
            gap_cnt        <= '0;
            write_config_n <= 1'b1;
            config_address <= '0;
            config_data    <= '0;
            timer_enable   <= 1'b0;
            frame_done     <= 1'b0;
            frames_done    <= '0;
            write_err      <= 1'b0;
            for (int i = 0; i <= NUM_CFG_REGS; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            frame_done <= 1'b0;
            write_err  <= host_we && (state != ST_IDLE);

            if (host_we && (state == ST_IDLE) && (host_addr <= RPT_ADDR)) begin
                shadow[host_addr] <= host_wdata;
            end

            if (abort) begin
                state          <= ST_IDLE;
                write_config_n <= 1'b1;
                config_address <= '0;
                config_data    <= '0;
                timer_enable   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state          <= ST_LOAD;
                            write_config_n <= 1'b0;
                            config_address <= '0;
                            config_data    <= shadow[0];
                            load_idx       <= IDX_W'(1);
                            frames_done    <= '0;
                        end
                    end
                    ST_LOAD: begin
                        // load_idx is the next word to present, not the one on the bus
                        if (load_idx == LOAD_END) begin
                            state          <= ST_RUN;
                            write_config_n <= 1'b1;
                            config_address <= '0;
                            config_data    <= '0;
                            timer_enable   <= 1'b1;
                            run_cnt        <= '0;
                        end else begin
                            write_config_n <= 1'b0;
                            config_address <= 6'(load_idx);
                            config_data    <= shadow[load_idx];
                            load_idx       <= load_idx + 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (run_exit) begin
                            state        <= ST_GAP;
                            timer_enable <= 1'b0;
                            frame_done   <= 1'b1;
                            gap_cnt      <= GAP_LOAD;
                            if (frames_done != 16'hFFFF) begin
                                frames_done <= frames_done + 16'd1;
                            end
                        end else if (run_cnt != RUN_MIN) begin
                            run_cnt <= run_cnt + 1'b1;
                        end
                    end
                    ST_GAP: begin
                        if (gap_cnt != '0) begin
                            gap_cnt <= gap_cnt - 1'b1;
                        end else if ((repeat_count == 16'd0) || (frames_done < repeat_count)) begin
                            state        <= ST_RUN;
                            timer_enable <= 1'b1;
                            run_cnt      <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_backend_config_sequencer.sv
// Bench for backend_config_sequencer: table of frame scenarios plus hand-written
// abort/host-write/reset sequences; config writes checked against a scoreboard queue.
module tb_backend_config_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        host_we;
    logic [3:0]  host_addr;
    logic [15:0] host_wdata;
    logic        start;
    logic        abort;
    logic        update_cycle_complete;
    logic        write_config_n;
    logic [5:0]  config_address;
    logic [15:0] config_data;
    logic        timer_enable;
    logic        busy;
    logic        frame_done;
    logic [15:0] frames_done;
    logic        write_err;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [5:0]  addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        logic [15:0] rep;
        int          d;
        int          exp_frames;
        int          exp_len;
    } vec_t;

    wr_t         exp_q[$];
    logic [15:0] shadow_m [11];
    vec_t        vecs [5];

    backend_config_sequencer dut (
        .clock                 (clock),
        .reset                 (reset),
        .host_we               (host_we),
        .host_addr             (host_addr),
        .host_wdata            (host_wdata),
        .start                 (start),
        .abort                 (abort),
        .update_cycle_complete (update_cycle_complete),
        .write_config_n        (write_config_n),
        .config_address        (config_address),
        .config_data           (config_data),
        .timer_enable          (timer_enable),
        .busy                  (busy),
        .frame_done            (frame_done),
        .frames_done           (frames_done),
        .write_err             (write_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic host_write(input logic [3:0] a, input logic [15:0] d);
        host_addr  = a;
        host_wdata = d;
        host_we    = 1'b1;
        tick();
        host_we = 1'b0;
        if (a <= 4'd10) shadow_m[a] = d;
    endtask

    task automatic do_start();
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(wr_t'{addr: 6'(i), data: shadow_m[i]});
        end
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_te(input string name);
        for (int k = 0; k < 20 && !timer_enable; k++) tick();
        chk(name, 32'(timer_enable), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wcn"}, 32'(write_config_n), 32'd1);
        chk({tag, "_addr"}, 32'(config_address), 32'd0);
        chk({tag, "_data"}, 32'(config_data), 32'd0);
        chk({tag, "_te"}, 32'(timer_enable), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_fd"}, 32'(frame_done), 32'd0);
        chk({tag, "_frames"}, 32'(frames_done), 32'd0);
        chk({tag, "_werr"}, 32'(write_err), 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int n);
        int  cyc, run_idx, frames, gap, wr, first_te;
        bit  in_gap;
        for (int i = 0; i < 10; i++) begin
            host_write(4'(i), 16'h1000 + 16'(n * 16) + 16'(i));
        end
        host_write(4'd10, v.rep);
        host_write(4'd12, 16'hDEAD);
        chk("ignored_addr_no_err", 32'(write_err), 32'd0);
        do_start();
        cyc = 1; run_idx = 0; frames = 0; gap = 0; wr = 0; first_te = -1; in_gap = 0;
        while (cyc < 400) begin
            if (!busy) begin
                if (in_gap) chk("gap_len_last", 32'(gap), 32'd2);
                break;
            end
            if (!write_config_n) wr++;
            if (timer_enable) begin
                if (first_te < 0) first_te = cyc;
                if (in_gap) begin
                    chk("gap_len", 32'(gap), 32'd2);
                    in_gap = 0;
                end
                update_cycle_complete = (run_idx >= v.d);
                run_idx++;
            end else begin
                update_cycle_complete = 1'b0;
                if (frame_done) begin
                    frames++;
                    chk("run_len", 32'(run_idx), 32'(v.exp_len));
                    run_idx = 0;
                    in_gap  = 1;
                    gap     = 0;
                end
                if (in_gap) gap++;
            end
            tick();
            cyc++;
        end
        update_cycle_complete = 1'b0;
        chk("seq_finished", 32'(busy), 32'd0);
        chk("write_cycles", 32'(wr), 32'd10);
        chk("first_te_cycle", 32'(first_te), 32'd11);
        chk("frame_pulses", 32'(frames), 32'(v.exp_frames));
        chk("frames_done", 32'(frames_done), 32'(v.exp_frames));
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // scoreboard: every active-low config write must match the next queued word
    initial begin : scoreboard
        wr_t e;
        forever begin
            @(negedge clock);
            if (!write_config_n) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_write", 32'(write_config_n), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_addr", 32'(config_address), 32'(e.addr));
                    chk("sb_data", 32'(config_data), 32'(e.data));
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin : main
        reset = 1'b1; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        start = 1'b0; abort = 1'b0; update_cycle_complete = 1'b0;
        for (int i = 0; i < 11; i++) shadow_m[i] = '0;
        tick(); tick(); tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();

        vecs[0] = '{16'd1, 5, 1, 6};
        vecs[1] = '{16'd3, 5, 3, 6};
        vecs[2] = '{16'd2, 0, 2, 3};
        vecs[3] = '{16'd2, 1, 2, 3};
        vecs[4] = '{16'd1, 3, 1, 4};
        for (int n = 0; n < 5; n++) run_vec(vecs[n], n);

        // abort at load index 4, start in the same cycle
        do_start();
        tick(); tick(); tick(); tick();
        chk("load_idx4_addr", 32'(config_address), 32'd4);
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        chk("abort_load_busy", 32'(busy), 32'd0);
        chk("abort_load_wcn", 32'(write_config_n), 32'd1);
        chk("abort_load_te", 32'(timer_enable), 32'd0);
        chk("abort_load_left", 32'(exp_q.size()), 32'd5);
        exp_q.delete();
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        chk("abort_start_idle_busy", 32'(busy), 32'd0);
        tick();
        chk("abort_start_idle_wcn", 32'(write_config_n), 32'd1);

        // abort during RUN after one completed frame, complete held for first frame
        host_write(4'd10, 16'd0);
        update_cycle_complete = 1'b1;
        do_start();
        for (int k = 0; k < 60 && !frame_done; k++) tick();
        chk("abort_run_fd_seen", 32'(frame_done), 32'd1);
        update_cycle_complete = 1'b0;
        wait_te("abort_run_te_up");
        tick(); tick();
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        chk("abort_run_te", 32'(timer_enable), 32'd0);
        chk("abort_run_busy", 32'(busy), 32'd0);
        chk("abort_run_wcn", 32'(write_config_n), 32'd1);
        chk("abort_run_frames_hold", 32'(frames_done), 32'd1);
        tick();
        chk("abort_run_start_ignored", 32'(busy), 32'd0);
        chk("abort_run_sb", 32'(exp_q.size()), 32'd0);

        // host write and start during RUN are dropped
        do_start();
        wait_te("we_run_te_up");
        host_addr = 4'd3; host_wdata = 16'hBEEF; host_we = 1'b1;
        tick();
        host_we = 1'b0;
        chk("we_run_err_pulse", 32'(write_err), 32'd1);
        tick();
        chk("we_run_err_clear", 32'(write_err), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_run_wcn", 32'(write_config_n), 32'd1);
        chk("start_run_te", 32'(timer_enable), 32'd1);
        chk("start_run_busy", 32'(busy), 32'd1);
        abort = 1'b1; tick(); abort = 1'b0;
        do_start();
        wait_te("reload_te_up");
        chk("reload_sb", 32'(exp_q.size()), 32'd0);

        // reset mid-RUN clears everything including the shadow bank
        tick();
        reset = 1'b1;
        tick();
        check_reset_outputs("midreset");
        reset = 1'b0;
        for (int i = 0; i < 11; i++) shadow_m[i] = '0;
        tick();
        do_start();
        wait_te("zero_load_te_up");
        chk("zero_load_sb", 32'(exp_q.size()), 32'd0);
        chk("zero_load_frames", 32'(frames_done), 32'd0);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("final_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
